// File: rtl/add_result_accumulator.sv
// add_result_accumulator
// Sums COUNT adder results, each taken as the 5-bit value {cout, sum}, into
// an ACC_W-bit block total. The total is then offered on a valid/ready
// handshake. The overflow flag is sticky and reports a wrap within the
// current block.
module add_result_accumulator #(
    parameter int ACC_W = 12,
    parameter int COUNT = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             cout,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Returns the widened sum, so the top bit is the carry out of the ACC_W-bit add.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [4:0]       v);
        return {1'b0, a} + {{(ACC_W-4){1'b0}}, v};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [ACC_W-1:0] acc_r, acc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             ovf_r, ovf_nxt_s;
    logic             out_valid_r;
    logic [ACC_W:0]   add_s;

    assign add_s     = acc_add(acc_r, {cout, sum});
    assign cnt_inc_s = cnt_r + ONE_C;

    // Next-state decode. clr wins over both accept and hand-off.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        if (clr) begin
            state_nxt_s = ACCUM;
            acc_nxt_s   = {ACC_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_valid) begin
                        acc_nxt_s = add_s[ACC_W-1:0];
                        ovf_nxt_s = ovf_r | add_s[ACC_W];
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == COUNT_C) begin
                            state_nxt_s = HOLD;
                        end else begin
                            state_nxt_s = ACCUM;
                        end
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt_s = ACCUM;
                        acc_nxt_s   = {ACC_W{1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        ovf_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ACCUM;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers. out_valid is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ovf_r       <= ovf_nxt_s;
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    assign in_ready  = (state_r == ACCUM);
    assign acc_out   = acc_r;
    assign acc_count = cnt_r;
    assign overflow  = ovf_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_add_result_accumulator.sv
// Directed bench for add_result_accumulator. Instance a uses the default
// parameters. Instance b (ACC_W=6, COUNT=4) exercises the wrap and the
// overflow flag.
module tb_add_result_accumulator;

    logic clk = 1'b0;
    logic rst;

    logic        a_clr, a_in_valid, a_in_ready, a_cout, a_out_valid, a_out_ready, a_overflow;
    logic [3:0]  a_sum;
    logic [11:0] a_acc_out;
    logic [3:0]  a_acc_count;

    logic        b_clr, b_in_valid, b_in_ready, b_cout, b_out_valid, b_out_ready, b_overflow;
    logic [3:0]  b_sum;
    logic [5:0]  b_acc_out;
    logic [2:0]  b_acc_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    add_result_accumulator #(.ACC_W(12), .COUNT(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sum(a_sum), .cout(a_cout), .acc_out(a_acc_out), .acc_count(a_acc_count),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .overflow(a_overflow)
    );

    add_result_accumulator #(.ACC_W(6), .COUNT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sum(b_sum), .cout(b_cout), .acc_out(b_acc_out), .acc_count(b_acc_count),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs change at the negedge, outputs are sampled at the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [4:0] val, input logic ordy, input logic c);
        a_in_valid  = v;
        a_cout      = val[4];
        a_sum       = val[3:0];
        a_out_ready = ordy;
        a_clr       = c;
        tick();
    endtask

    task automatic drive_b(input logic v, input logic [4:0] val);
        b_in_valid  = v;
        b_cout      = val[4];
        b_sum       = val[3:0];
        b_out_ready = 1'b0;
        b_clr       = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        a_clr = 1'b0; a_in_valid = 1'b0; a_cout = 1'b0; a_sum = 4'h0; a_out_ready = 1'b0;
        b_clr = 1'b0; b_in_valid = 1'b0; b_cout = 1'b0; b_sum = 4'h0; b_out_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_acc",      a_acc_out,   0);
        chk("rst_cnt",      a_acc_count, 0);
        chk("rst_valid",    a_out_valid, 0);
        chk("rst_ovf",      a_overflow,  0);
        chk("rst_in_ready", a_in_ready,  1);
        chk("rst_b_acc",    b_acc_out,   0);
        rst = 1'b0;
        tick();

        // Eight back-to-back accepts of 31
        for (int i = 0; i < 7; i++) drive_a(1'b1, 5'd31, 1'b0, 1'b0);
        chk("b2b_acc7",   a_acc_out,   217);
        chk("b2b_cnt7",   a_acc_count, 7);
        chk("b2b_valid7", a_out_valid, 0);
        drive_a(1'b1, 5'd31, 1'b0, 1'b0);
        chk("b2b_acc",      a_acc_out,   248);
        chk("b2b_cnt",      a_acc_count, 8);
        chk("b2b_valid",    a_out_valid, 1);
        chk("b2b_ovf",      a_overflow,  0);
        chk("b2b_in_ready", a_in_ready,  0);

        // Hand-off
        drive_a(1'b0, 5'd0, 1'b1, 1'b0);
        chk("ho_acc",      a_acc_out,   0);
        chk("ho_cnt",      a_acc_count, 0);
        chk("ho_valid",    a_out_valid, 0);
        chk("ho_in_ready", a_in_ready,  1);

        // Same stimulus with in_valid on every other cycle
        for (int i = 0; i < 16; i++) begin
            drive_a((i % 2) == 0, 5'd31, 1'b0, 1'b0);
            chk("gap_cnt", a_acc_count, (i / 2) + 1);
        end
        chk("gap_acc",   a_acc_out,   248);
        chk("gap_valid", a_out_valid, 1);

        // HOLD stall with in_valid high: nothing moves
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 5'd7, 1'b0, 1'b0);
            chk("stall_acc",      a_acc_out,   248);
            chk("stall_cnt",      a_acc_count, 8);
            chk("stall_in_ready", a_in_ready,  0);
            chk("stall_valid",    a_out_valid, 1);
        end
        drive_a(1'b1, 5'd7, 1'b1, 1'b0);
        chk("stall_ho_acc",      a_acc_out,   0);
        chk("stall_ho_cnt",      a_acc_count, 0);
        chk("stall_ho_in_ready", a_in_ready,  1);

        // clr discards the result presented with it
        for (int i = 0; i < 3; i++) drive_a(1'b1, 5'd5, 1'b0, 1'b0);
        chk("clr_pre_acc", a_acc_out,   15);
        chk("clr_pre_cnt", a_acc_count, 3);
        drive_a(1'b1, 5'd9, 1'b0, 1'b1);
        chk("clr_acc", a_acc_out,   0);
        chk("clr_cnt", a_acc_count, 0);
        drive_a(1'b1, 5'd2, 1'b0, 1'b0);
        chk("clr_after_acc", a_acc_out,   2);
        chk("clr_after_cnt", a_acc_count, 1);
        drive_a(1'b0, 5'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-block
        drive_a(1'b1, 5'd20, 1'b0, 1'b0);
        chk("mid_pre_acc", a_acc_out, 20);
        a_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_acc",      a_acc_out,   0);
        chk("mid_rst_cnt",      a_acc_count, 0);
        chk("mid_rst_in_ready", a_in_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Asynchronous reset in HOLD
        for (int i = 0; i < 8; i++) drive_a(1'b1, 5'd1, 1'b0, 1'b0);
        chk("hold_pre_acc",   a_acc_out,   8);
        chk("hold_pre_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("hold_rst_acc",      a_acc_out,   0);
        chk("hold_rst_cnt",      a_acc_count, 0);
        chk("hold_rst_valid",    a_out_valid, 0);
        chk("hold_rst_in_ready", a_in_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Narrow instance: four accepts of 31 wrap past 64
        drive_b(1'b1, 5'd31);
        drive_b(1'b1, 5'd31);
        chk("w_acc2", b_acc_out,  62);
        chk("w_ovf2", b_overflow, 0);
        drive_b(1'b1, 5'd31);
        chk("w_acc3", b_acc_out,  29);
        chk("w_ovf3", b_overflow, 1);
        drive_b(1'b1, 5'd31);
        chk("w_acc",   b_acc_out,   60);
        chk("w_ovf",   b_overflow,  1);
        chk("w_cnt",   b_acc_count, 4);
        chk("w_valid", b_out_valid, 1);
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        tick();
        chk("w_ho_ovf", b_overflow, 0);
        chk("w_ho_acc", b_acc_out,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_result_accumulator.md
Name: add_result_accumulator

Overview:
Downstream consumer of the 4-bit two-operand adder. Each accepted adder result is treated as a 5-bit value {cout, sum}. The block accumulates COUNT such results into an ACC_W-bit sum, then presents the block total on a valid/ready output handshake. It is the sequential stage that turns per-nibble adder results into a running block sum for the next stage.

Parameters:
ACC_W, 12, accumulator/result width in bits; must be >= 5
COUNT, 8, adder results accumulated per output block; must be >= 1
CNT_W, 4, width of acc_count; must satisfy 2^CNT_W > COUNT

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous block abort/clear
in_valid  input  1  adder result present on sum/cout
in_ready  output  1  block can accept a result this cycle
sum  input  4  adder sum
cout  input  1  adder carry out
acc_out  output  ACC_W  registered running/final accumulator value
acc_count  output  CNT_W  results accepted in the current block
out_valid  output  1  acc_out holds a completed block total
out_ready  input  1  downstream accepts the completed block
overflow  output  1  sticky: the current block wrapped past 2^ACC_W

Behaviour:
- One clock; reset is asynchronous and active-high (rst), clock is clk.
- Reset values: acc_out=0, acc_count=0, out_valid=0, overflow=0, state=ACCUM, so in_ready=1.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: the block accepts a result when in_valid && in_ready. On accept:
  - acc_out <= (acc_out + {cout,sum}) mod 2^ACC_W, with the 5-bit value zero-extended.
  - overflow <= overflow | carry-out of that ACC_W-bit add.
  - acc_count <= acc_count + 1.
- Cycles with in_valid=0 leave all state unchanged. Gaps in the input stream are allowed.
- ACCUM -> HOLD: on the accept that makes acc_count reach COUNT. acc_out and acc_count are final and out_valid=1 from the next cycle. Latency from the last accept to out_valid is 1 cycle.
- HOLD:
  - acc_out, acc_count and overflow are held stable. in_valid is ignored (in_ready=0).
  - On out_ready=1: acc_out<=0, acc_count<=0, overflow<=0, state<=ACCUM.
  - in_ready=1 again on the following cycle. There is no same-cycle accept on the hand-off cycle.
- out_valid, once asserted, stays asserted until out_ready is sampled high. It is never withdrawn, except by clr or rst.
- clr has priority over accept and hand-off. It forces acc_out=0, acc_count=0, overflow=0, state=ACCUM on the next edge. A result presented in the same cycle as clr is discarded.
- rst asserted mid-block or in HOLD: immediate return to reset values; any partial sum is lost.
- COUNT=1: every accepted result moves the block straight to HOLD.
- All outputs are registered except in_ready, which is decoded directly from state.

Test Plan:
- Reset, then 8 accepts of {cout=1,sum=4'hF} back-to-back -> acc_out=248, acc_count=8, out_valid=1 one cycle after the 8th accept, overflow=0.
- Same stimulus with in_valid deasserted every other cycle -> same 248 result, and acc_count increments only on accepts.
- ACC_W=6, COUNT=4, four accepts of value 31 -> acc_out=60 (124 mod 64), overflow=1.
- In HOLD, out_ready=0 for 5 cycles while in_valid=1 with value 7 -> acc_out stays constant and in_ready=0. Then out_ready=1 -> next cycle acc_out=0, acc_count=0, in_ready=1.
- After 3 accepts of value 5 (acc_out=15), pulse clr together with in_valid (value 9) -> acc_out=0, acc_count=0, and value 9 is not added.
- Assert rst asynchronously between clock edges mid-block (acc_out=20) and in HOLD -> outputs go to 0 immediately without a clock edge, and state returns to ACCUM.
